// File: rtl/axi4l_if.sv
// AXI4-Lite channel bundle. The master modport issues requests and the slave modport returns responses.
interface axi4l_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awprot;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4l_rr_arbiter.sv
// Round-robin sharing of one AXI4-Lite slave among NUMM masters.
// Read and write channels are arbitrated independently, and each grant covers a whole transaction.
module axi4l_rr_arbiter #(
  parameter int unsigned NUMM   = 3,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  axi4l_if.slave          axim [NUMM],
  axi4l_if.master         axis,
  output logic [NUMM-1:0] wr_grant,
  output logic [NUMM-1:0] rd_grant
);
  localparam int unsigned IW     = $clog2(NUMM);
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam logic [NUMM-1:0] GNT_ONE = NUMM'(1);

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_e;

  w_state_e        r_wstate, w_wstate_nxt;
  r_state_e        r_rstate, w_rstate_nxt;
  logic [IW-1:0]   r_wgnt, w_wgnt_nxt, r_wr_ptr, w_wr_ptr_nxt, w_wpick;
  logic [IW-1:0]   r_rgnt, w_rgnt_nxt, r_rd_ptr, w_rd_ptr_nxt, w_rpick;
  logic [NUMM-1:0] r_wr_grant, w_wr_grant_nxt, r_rd_grant, w_rd_grant_nxt;
  logic            r_aw_done, w_aw_done_nxt, r_w_done, w_w_done_nxt;

  logic [NUMM-1:0]   w_awvalid, w_wvalid, w_bready, w_arvalid, w_rready;
  logic [ADDR_W-1:0] w_awaddr [NUMM];
  logic [2:0]        w_awprot [NUMM];
  logic [DATA_W-1:0] w_wdata  [NUMM];
  logic [STRB_W-1:0] w_wstrb  [NUMM];
  logic [ADDR_W-1:0] w_araddr [NUMM];
  logic [2:0]        w_arprot [NUMM];

  logic w_aw_open, w_w_open, w_b_open, w_ar_open, w_r_open;
  logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;

  // First requester at or after ptr, searching circularly.
  function automatic logic [IW-1:0] rr_pick(input logic [NUMM-1:0] req, input logic [IW-1:0] ptr);
    logic [IW-1:0] pick;
    logic [IW-1:0] cand;
    pick = ptr;
    for (int k = int'(NUMM) - 1; k >= 0; k--) begin
      cand = IW'((int'(ptr) + k) % int'(NUMM));
      if (req[cand]) pick = cand;
    end
    return pick;
  endfunction

  function automatic logic [IW-1:0] rr_next(input logic [IW-1:0] idx);
    return (idx == IW'(NUMM - 1)) ? '0 : idx + IW'(1);
  endfunction

  assign w_aw_open = (r_wstate == W_ADDR) && !r_aw_done;
  assign w_w_open  = (r_wstate == W_ADDR) && !r_w_done;
  assign w_b_open  = (r_wstate == W_RESP);
  assign w_ar_open = (r_rstate == R_ADDR);
  assign w_r_open  = (r_rstate == R_DATA);

  for (genvar i = 0; i < NUMM; i++) begin : g_up
    localparam logic [IW-1:0] IDX = IW'(i);
    assign w_awvalid[i] = axim[i].awvalid;
    assign w_awaddr[i]  = axim[i].awaddr;
    assign w_awprot[i]  = axim[i].awprot;
    assign w_wvalid[i]  = axim[i].wvalid;
    assign w_wdata[i]   = axim[i].wdata;
    assign w_wstrb[i]   = axim[i].wstrb;
    assign w_bready[i]  = axim[i].bready;
    assign w_arvalid[i] = axim[i].arvalid;
    assign w_araddr[i]  = axim[i].araddr;
    assign w_arprot[i]  = axim[i].arprot;
    assign w_rready[i]  = axim[i].rready;

    assign axim[i].awready = w_aw_open && (r_wgnt == IDX) && axis.awready;
    assign axim[i].wready  = w_w_open  && (r_wgnt == IDX) && axis.wready;
    assign axim[i].bvalid  = w_b_open  && (r_wgnt == IDX) && axis.bvalid;
    assign axim[i].bresp   = axis.bresp;
    assign axim[i].arready = w_ar_open && (r_rgnt == IDX) && axis.arready;
    assign axim[i].rvalid  = w_r_open  && (r_rgnt == IDX) && axis.rvalid;
    assign axim[i].rdata   = axis.rdata;
    assign axim[i].rresp   = axis.rresp;
  end

  // Downstream path is a plain mux on the registered owner, gated by phase.
  assign axis.awvalid = w_aw_open && w_awvalid[r_wgnt];
  assign axis.awaddr  = w_awaddr[r_wgnt];
  assign axis.awprot  = w_awprot[r_wgnt];
  assign axis.wvalid  = w_w_open && w_wvalid[r_wgnt];
  assign axis.wdata   = w_wdata[r_wgnt];
  assign axis.wstrb   = w_wstrb[r_wgnt];
  assign axis.bready  = w_b_open && w_bready[r_wgnt];
  assign axis.arvalid = w_ar_open && w_arvalid[r_rgnt];
  assign axis.araddr  = w_araddr[r_rgnt];
  assign axis.arprot  = w_arprot[r_rgnt];
  assign axis.rready  = w_r_open && w_rready[r_rgnt];

  assign w_aw_hs = axis.awvalid && axis.awready;
  assign w_w_hs  = axis.wvalid  && axis.wready;
  assign w_b_hs  = axis.bvalid  && axis.bready;
  assign w_ar_hs = axis.arvalid && axis.arready;
  assign w_r_hs  = axis.rvalid  && axis.rready;

  assign w_wpick = rr_pick(w_awvalid, r_wr_ptr);
  assign w_rpick = rr_pick(w_arvalid, r_rd_ptr);

  always_comb begin
    w_wstate_nxt   = r_wstate;
    w_wgnt_nxt     = r_wgnt;
    w_wr_ptr_nxt   = r_wr_ptr;
    w_wr_grant_nxt = r_wr_grant;
    w_aw_done_nxt  = r_aw_done;
    w_w_done_nxt   = r_w_done;
    case (r_wstate)
      W_IDLE: begin
        if (|w_awvalid) begin
          w_wstate_nxt   = W_ADDR;
          w_wgnt_nxt     = w_wpick;
          w_wr_grant_nxt = GNT_ONE << w_wpick;
          w_aw_done_nxt  = 1'b0;
          w_w_done_nxt   = 1'b0;
        end
      end
      W_ADDR: begin
        // AW and W complete independently, in either order or together.
        w_aw_done_nxt = r_aw_done || w_aw_hs;
        w_w_done_nxt  = r_w_done || w_w_hs;
        if (w_aw_done_nxt && w_w_done_nxt) w_wstate_nxt = W_RESP;
      end
      W_RESP: begin
        if (w_b_hs) begin
          w_wstate_nxt   = W_IDLE;
          w_wr_grant_nxt = '0;
          w_wr_ptr_nxt   = rr_next(r_wgnt);
        end
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    w_rstate_nxt   = r_rstate;
    w_rgnt_nxt     = r_rgnt;
    w_rd_ptr_nxt   = r_rd_ptr;
    w_rd_grant_nxt = r_rd_grant;
    case (r_rstate)
      R_IDLE: begin
        if (|w_arvalid) begin
          w_rstate_nxt   = R_ADDR;
          w_rgnt_nxt     = w_rpick;
          w_rd_grant_nxt = GNT_ONE << w_rpick;
        end
      end
      R_ADDR: begin
        if (w_ar_hs) w_rstate_nxt = R_DATA;
      end
      R_DATA: begin
        if (w_r_hs) begin
          w_rstate_nxt   = R_IDLE;
          w_rd_grant_nxt = '0;
          w_rd_ptr_nxt   = rr_next(r_rgnt);
        end
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wstate   <= W_IDLE;
      r_wgnt     <= '0;
      r_wr_ptr   <= '0;
      r_wr_grant <= '0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_rstate   <= R_IDLE;
      r_rgnt     <= '0;
      r_rd_ptr   <= '0;
      r_rd_grant <= '0;
    end else begin
      r_wstate   <= w_wstate_nxt;
      r_wgnt     <= w_wgnt_nxt;
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_wr_grant <= w_wr_grant_nxt;
      r_aw_done  <= w_aw_done_nxt;
      r_w_done   <= w_w_done_nxt;
      r_rstate   <= w_rstate_nxt;
      r_rgnt     <= w_rgnt_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_rd_grant <= w_rd_grant_nxt;
    end
  end

  assign wr_grant = r_wr_grant;
  assign rd_grant = r_rd_grant;
endmodule

// File: tb/tb_axi4l_rr_arbiter.sv
// Directed bench for axi4l_rr_arbiter with three masters and a behavioural zero-wait slave.
module tb_axi4l_rr_arbiter;
  localparam int unsigned NUMM = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NUMM-1:0] wr_grant, rd_grant;

  axi4l_if axim [NUMM] ();
  axi4l_if axis ();

  axi4l_rr_arbiter #(.NUMM(NUMM)) dut (
    .clk(clk), .rst(rst), .axim(axim), .axis(axis),
    .wr_grant(wr_grant), .rd_grant(rd_grant)
  );

  logic [NUMM-1:0] m_awvalid = '0, m_wvalid = '0, m_bready = '0, m_arvalid = '0, m_rready = '0;
  logic [NUMM-1:0] m_awready, m_wready, m_bvalid, m_arready, m_rvalid;
  logic [31:0]     m_awaddr [NUMM];
  logic [31:0]     m_wdata  [NUMM];
  logic [31:0]     m_araddr [NUMM];
  logic [31:0]     m_rdata  [NUMM];
  logic [1:0]      m_bresp  [NUMM];

  for (genvar g = 0; g < NUMM; g++) begin : g_m
    assign axim[g].awvalid = m_awvalid[g];
    assign axim[g].awaddr  = m_awaddr[g];
    assign axim[g].awprot  = 3'b000;
    assign axim[g].wvalid  = m_wvalid[g];
    assign axim[g].wdata   = m_wdata[g];
    assign axim[g].wstrb   = 4'hF;
    assign axim[g].bready  = m_bready[g];
    assign axim[g].arvalid = m_arvalid[g];
    assign axim[g].araddr  = m_araddr[g];
    assign axim[g].arprot  = 3'b000;
    assign axim[g].rready  = m_rready[g];
    assign m_awready[g] = axim[g].awready;
    assign m_wready[g]  = axim[g].wready;
    assign m_bvalid[g]  = axim[g].bvalid;
    assign m_bresp[g]   = axim[g].bresp;
    assign m_arready[g] = axim[g].arready;
    assign m_rvalid[g]  = axim[g].rvalid;
    assign m_rdata[g]   = axim[g].rdata;
  end

  // Behavioural slave: B after s_b_lat cycles, R one cycle after AR, rdata tagged from araddr.
  logic        s_aw_en = 1'b1;
  int          s_b_lat = 1;
  logic        s_bvalid = 1'b0, s_rvalid = 1'b0, s_aw_got = 1'b0, s_w_got = 1'b0;
  int          s_bcnt = 0, aw_cnt = 0, w_cnt = 0;
  logic [31:0] s_rdata = '0, s_awaddr = '0, s_wdata = '0;
  longint      cyc = 0, aw_t = 0, w_t = 0;

  assign axis.awready = s_aw_en;
  assign axis.wready  = 1'b1;
  assign axis.bvalid  = s_bvalid;
  assign axis.bresp   = 2'b00;
  assign axis.arready = 1'b1;
  assign axis.rvalid  = s_rvalid;
  assign axis.rdata   = s_rdata;
  assign axis.rresp   = 2'b00;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      s_bvalid <= 1'b0; s_rvalid <= 1'b0; s_aw_got <= 1'b0; s_w_got <= 1'b0; s_bcnt <= 0;
    end else begin
      if (axis.awvalid && axis.awready) begin
        aw_cnt <= aw_cnt + 1; s_awaddr <= axis.awaddr; s_aw_got <= 1'b1; aw_t <= cyc;
      end
      if (axis.wvalid && axis.wready) begin
        w_cnt <= w_cnt + 1; s_wdata <= axis.wdata; s_w_got <= 1'b1; w_t <= cyc;
      end
      if (s_aw_got && s_w_got && !s_bvalid) begin
        if (s_bcnt >= s_b_lat - 1) begin
          s_bvalid <= 1'b1; s_aw_got <= 1'b0; s_w_got <= 1'b0; s_bcnt <= 0;
        end else s_bcnt <= s_bcnt + 1;
      end
      if (s_bvalid && axis.bready) s_bvalid <= 1'b0;
      if (axis.arvalid && axis.arready) begin
        s_rvalid <= 1'b1; s_rdata <= 32'hA000_0000 | axis.araddr;
      end else if (s_rvalid && axis.rready) s_rvalid <= 1'b0;
    end
  end

  int stray_b = 0, stray_r = 0;
  int b_cnt [NUMM] = '{default: 0};
  always @(negedge clk) begin
    if (!rst) begin
      for (int j = 0; j < NUMM; j++) begin
        if (m_bvalid[j] && !wr_grant[j]) stray_b++;
        if (m_rvalid[j] && !rd_grant[j]) stray_r++;
        if (m_bvalid[j] && m_bready[j]) b_cnt[j]++;
      end
    end
  end

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_write(input int m, input logic [31:0] a, input logic [31:0] d,
                          output logic [1:0] resp, output logic ok, output longint t_done);
    logic aw_hs, w_hs, b_hs;
    m_awaddr[m] = a; m_wdata[m] = d;
    m_awvalid[m] = 1'b1; m_wvalid[m] = 1'b1; m_bready[m] = 1'b1;
    ok = 1'b0; resp = 2'b11; t_done = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      aw_hs = m_awvalid[m] & m_awready[m];
      w_hs  = m_wvalid[m] & m_wready[m];
      b_hs  = m_bvalid[m] & m_bready[m];
      if (b_hs) resp = m_bresp[m];
      @(posedge clk); #1;
      if (aw_hs) m_awvalid[m] = 1'b0;
      if (w_hs) m_wvalid[m] = 1'b0;
      if (b_hs) begin ok = 1'b1; t_done = cyc; break; end
    end
    m_awvalid[m] = 1'b0; m_wvalid[m] = 1'b0; m_bready[m] = 1'b0;
  endtask

  task automatic do_read(input int m, input logic [31:0] a,
                         output logic [31:0] data, output logic ok, output longint t_done);
    logic ar_hs, r_hs;
    m_araddr[m] = a; m_arvalid[m] = 1'b1; m_rready[m] = 1'b1;
    ok = 1'b0; data = '0; t_done = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      ar_hs = m_arvalid[m] & m_arready[m];
      r_hs  = m_rvalid[m] & m_rready[m];
      if (r_hs) data = m_rdata[m];
      @(posedge clk); #1;
      if (ar_hs) m_arvalid[m] = 1'b0;
      if (r_hs) begin ok = 1'b1; t_done = cyc; break; end
    end
    m_arvalid[m] = 1'b0; m_rready[m] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [1:0]      resp;
    logic            ok, ok2, seen, hs1;
    logic [31:0]     rd;
    longint          t_w, t_r;
    int              aw0, w0, rr_n, rd_tot, rd_bad;
    int              b0 [NUMM];
    int              ar_cnt [NUMM];
    int              rr_cyc [6];
    logic [NUMM-1:0] rr_gnt [6];
    logic [NUMM-1:0] prev_g, ar_hs;

    for (int j = 0; j < NUMM; j++) begin
      m_awaddr[j] = '0; m_wdata[j] = '0; m_araddr[j] = 32'h100 + 32'(4 * j);
    end

    // Reset held with every master requesting.
    rst = 1'b1;
    m_awvalid = '1; m_wvalid = '1; m_bready = '1; m_arvalid = '1; m_rready = '1;
    tick(); tick();
    chk("rst_wr_grant", wr_grant, 0);
    chk("rst_rd_grant", rd_grant, 0);
    chk("rst_up_handshakes", {m_awready, m_wready, m_bvalid, m_arready, m_rvalid}, 0);
    chk("rst_dn_handshakes", {axis.awvalid, axis.wvalid, axis.bready, axis.arvalid, axis.rready}, 0);
    rst = 1'b0;
    tick();
    chk("rel_wr_grant", wr_grant, 3'b001);
    chk("rel_rd_grant", rd_grant, 3'b001);
    rst = 1'b1;
    m_awvalid = '0; m_wvalid = '0; m_bready = '0; m_arvalid = '0; m_rready = '0;
    tick();
    rst = 1'b0;
    tick();

    // Single write from master 1.
    aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
    do_write(1, 32'h10, 32'hDEAD_BEEF, resp, ok, t_w);
    chk("sw_done", ok, 1);
    chk("sw_bresp", resp, 2'b00);
    chk("sw_aw_count", 64'(aw_cnt - aw0), 1);
    chk("sw_w_count", 64'(w_cnt - w0), 1);
    chk("sw_awaddr", s_awaddr, 32'h10);
    chk("sw_wdata", s_wdata, 32'hDEAD_BEEF);
    chk("sw_b_m0", 64'(b_cnt[0] - b0[0]), 0);
    chk("sw_b_m1", 64'(b_cnt[1] - b0[1]), 1);
    chk("sw_b_m2", 64'(b_cnt[2] - b0[2]), 0);
    chk("sw_wr_ptr", dut.r_wr_ptr, 2);

    // All three masters read continuously, two reads each.
    rr_n = 0; rd_tot = 0; rd_bad = 0; prev_g = '0;
    for (int j = 0; j < NUMM; j++) ar_cnt[j] = 0;
    m_arvalid = '1; m_rready = '1;
    for (int c = 0; c < 60 && rd_tot < 6; c++) begin
      @(negedge clk);
      if (rd_grant != '0 && prev_g == '0 && rr_n < 6) begin
        rr_gnt[rr_n] = rd_grant; rr_cyc[rr_n] = c; rr_n++;
      end
      prev_g = rd_grant;
      for (int j = 0; j < NUMM; j++) begin
        ar_hs[j] = m_arvalid[j] & m_arready[j];
        if (m_rvalid[j] && m_rready[j]) begin
          rd_tot++;
          if (m_rdata[j] !== (32'hA000_0000 | m_araddr[j])) rd_bad++;
        end
      end
      @(posedge clk); #1;
      for (int j = 0; j < NUMM; j++) begin
        if (ar_hs[j]) begin
          ar_cnt[j]++;
          if (ar_cnt[j] == 2) m_arvalid[j] = 1'b0;
        end
      end
    end
    m_arvalid = '0; m_rready = '0;
    chk("rr_grant_count", 64'(rr_n), 6);
    chk("rr_read_count", 64'(rd_tot), 6);
    chk("rr_rdata_routing", 64'(rd_bad), 0);
    if (rr_n == 6) begin
      chk("rr_order_0", rr_gnt[0], 3'b001);
      chk("rr_order_1", rr_gnt[1], 3'b010);
      chk("rr_order_2", rr_gnt[2], 3'b100);
      chk("rr_order_3", rr_gnt[3], 3'b001);
      chk("rr_order_4", rr_gnt[4], 3'b010);
      chk("rr_order_5", rr_gnt[5], 3'b100);
      for (int k = 1; k < 6; k++) chk("rr_period", 64'(rr_cyc[k] - rr_cyc[k-1]), 3);
    end

    // Concurrent write (master 0, slow B) and read (master 2).
    s_b_lat = 5;
    fork
      do_write(0, 32'h20, 32'h1234_5678, resp, ok, t_w);
      do_read(2, 32'h30, rd, ok2, t_r);
    join
    s_b_lat = 1;
    chk("cc_write_done", ok, 1);
    chk("cc_read_done", ok2, 1);
    chk("cc_bresp", resp, 2'b00);
    chk("cc_rdata", rd, 32'hA000_0030);
    chk("cc_wdata", s_wdata, 32'h1234_5678);
    chk("cc_read_first", 64'(t_r < t_w), 1);

    // W accepted while AW is held off by the slave.
    aw0 = aw_cnt; b0 = b_cnt; seen = 1'b0;
    s_aw_en = 1'b0;
    fork
      do_write(2, 32'h44, 32'hCAFE_F00D, resp, ok, t_w);
      begin
        for (int c = 0; c < 20; c++) begin
          @(negedge clk);
          if (wr_grant[2]) begin
            if (!seen) begin
              chk("wa_first_wready", m_wready[2], 1);
              chk("wa_awready_low", m_awready[2], 0);
              seen = 1'b1;
            end else begin
              chk("wa_wready_masked", m_wready[2], 0);
              chk("wa_aw_forwarded", axis.awvalid, 1);
              chk("wa_no_early_b", m_bvalid[2], 0);
              break;
            end
          end
        end
        @(posedge clk); #1;
        s_aw_en = 1'b1;
      end
    join
    chk("wa_seen_grant", seen, 1);
    chk("wa_write_done", ok, 1);
    chk("wa_w_before_aw", 64'(w_t < aw_t), 1);
    chk("wa_aw_count", 64'(aw_cnt - aw0), 1);
    chk("wa_b_count", 64'(b_cnt[2] - b0[2]), 1);
    chk("wa_awaddr", s_awaddr, 32'h44);

    // Reset during R_DATA with rvalid pending.
    m_araddr[1] = 32'h50; m_rready[1] = 1'b0; m_arvalid[1] = 1'b1; ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      hs1 = m_arvalid[1] & m_arready[1];
      @(posedge clk); #1;
      if (hs1) begin m_arvalid[1] = 1'b0; ok = 1'b1; break; end
    end
    chk("mr_ar_done", ok, 1);
    @(negedge clk);
    chk("mr_rvalid_pending", m_rvalid[1], 1);
    @(posedge clk); #1;
    rst = 1'b1;
    tick();
    chk("mr_rd_grant", rd_grant, 0);
    chk("mr_rvalid_all", m_rvalid, 0);
    rst = 1'b0;
    do_read(1, 32'h54, rd, ok, t_r);
    chk("mr_read_done", ok, 1);
    chk("mr_rdata", rd, 32'hA000_0054);

    chk("stray_bvalid", 64'(stray_b), 0);
    chk("stray_rvalid", 64'(stray_r), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
